sync_fifo_flex: RTL
===================

Name: sync_fifo_flex

Overview:
- Parametrised successor to the UART byte FIFO. It is a single-clock, show-ahead FIFO with configurable data width and depth.
- Adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a synchronous flush.
- Accepts a simultaneous push and pop when full.
- Sits between the UART RX/TX datapaths and the loopback/host logic.

Parameters:
- DWIDTH, 8, data word width in bits.
- AWIDTH, 4, address width; DEPTH = 2**AWIDTH entries.
- AFULL_TH, 12, almost_full asserts when count >= AFULL_TH. Legal range: AEMPTY_TH < AFULL_TH <= DEPTH.
- AEMPTY_TH, 4, almost_empty asserts when count <= AEMPTY_TH. Legal range: 0 <= AEMPTY_TH < AFULL_TH.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- wr  input  1  push request.
- wdata  input  DWIDTH  push data.
- rd  input  1  pop request (acknowledges the current rdata).
- flush  input  1  synchronous clear of contents.
- clr_err  input  1  synchronous clear of the sticky error flags.
- rdata  output  DWIDTH  oldest entry (show-ahead).
- count  output  AWIDTH+1  occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_TH.
- almost_empty  output  1  count <= AEMPTY_TH.
- overflow  output  1  sticky: a push was rejected.
- underflow  output  1  sticky: a pop was rejected.

Behaviour:
- Storage: DEPTH x DWIDTH register array, not reset. Write pointer (wptr), read pointer (rptr), AWIDTH bits each, wrap modulo DEPTH. count is a separate registered counter.
- Reset (async): wptr=0, rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. rdata is don't-care while empty.
- All flags are decoded from registered count only. There is no combinational path from wr/rd to any flag.
- rdata = mem[rptr], combinational from the registered pointer. Zero-latency show-ahead: a word is visible on the cycle after its push edge.
- pop_ok = rd & ~empty.
- push_ok = wr & (~full | pop_ok). When full, a simultaneous push and pop are both accepted.
- When empty and wr & rd: only the push is accepted; the pop is rejected.
- On each edge, if push_ok: mem[wptr] <= wdata and wptr += 1. If pop_ok: rptr += 1.
- count update: +1 if push only, -1 if pop only, unchanged if both or neither.
- Error flags:
  - overflow sets when wr & ~push_ok.
  - underflow sets when rd & ~pop_ok.
  - clr_err clears both flags. If a set and clr_err occur in the same cycle, set wins.
- flush has priority over push and pop: wptr=0, rptr=0, count=0. A concurrent wr/rd is discarded and does not set the error flags. Error flags are otherwise unaffected by flush.
- Wrap-around: pointers wrap DEPTH-1 -> 0 with no bubble. Ordering is preserved across any number of wraps.
- Reset mid-operation: all outputs return to reset values immediately, without a clock edge. Contents are lost.
- count never exceeds DEPTH and never goes below 0 under any input sequence.

Test Plan (defaults, DEPTH=16):
1. After reset, push 0x00..0x0F on 16 consecutive cycles:
   - count increments by 1 per cycle.
   - almost_empty drops when count=5; almost_full rises at count=12; full rises at count=16.
   - A 17th push leaves count=16 and sets overflow=1.
2. From the full state, pop 16 times:
   - rdata reads 0x00..0x0F in order; empty=1 after the last pop.
   - A 17th pop leaves count=0 and sets underflow=1.
   - clr_err then clears both error flags.
3. Full, assert wr & rd with wdata=0xA5:
   - 0x00 is popped; count stays 16; full stays 1; overflow stays 0.
   - After draining, the last word read is 0xA5.
4. Empty, assert wr & rd with wdata=0x3C:
   - count=1, empty=0, and rdata=0x3C on the next cycle; underflow=1.
5. Interleave 40 push/pop cycles holding count between 2 and 4:
   - Both pointers wrap at least twice.
   - All words pop in order with no loss or duplication.
6. Flush and reset behaviour:
   - At count=9, assert flush together with wr (wdata=0x55): next cycle count=0, empty=1, almost_empty=1; 0x55 is never read.
   - Assert rst between clock edges at count=5: all flags reach their reset values before the next edge.

Source files
------------

// File: rtl/sync_fifo_flex.sv
// Single-clock show-ahead FIFO with occupancy count, threshold flags and sticky error flags.
// Latency: a pushed word is visible on rdata the cycle after its push edge; all flags come from registered count.
// Backpressure: pushes are dropped when full unless a pop is accepted on the same edge; both drop and empty-pop set sticky errors.
module sync_fifo_flex #(
    parameter int DWIDTH    = 8,
    parameter int AWIDTH    = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              rd,
    input  logic              flush,
    input  logic              clr_err,
    output logic [DWIDTH-1:0] rdata,
    output logic [AWIDTH:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);
    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_C  = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] AFULL_C  = (AWIDTH+1)'(AFULL_TH);
    localparam logic [AWIDTH:0] AEMPTY_C = (AWIDTH+1)'(AEMPTY_TH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wptr;
    logic [AWIDTH-1:0] rptr;
    logic              pop_ok;
    logic              push_ok;

    // A full FIFO still takes a push when the same edge frees a slot.
    assign pop_ok  = rd & ~empty;
    assign push_ok = wr & (~full | pop_ok);

    assign rdata        = mem[rptr];
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Set after clear so a new error in the clearing cycle is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (clr_err) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            if (!flush && wr && !push_ok) begin
                overflow <= 1'b1;
            end
            if (!flush && rd && !pop_ok) begin
                underflow <= 1'b1;
            end
        end
    end
endmodule
